// File: rtl/mkio_pkg.sv
// Shared types and helpers for the MKIO remote-terminal sequencer.
package mkio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_DATA,
    GAP,
    TX_STATUS,
    TX_RD,
    TX_DATA,
    DRAIN
  } seq_state_e;

  typedef struct packed {
    logic [4:0] addr;
    logic       tr;
    logic [4:0] sa;
    logic [4:0] wc;
  } cmd_word_t;

  localparam int unsigned ME_BIT = 10;

  // A word-count field of zero encodes a 32-word message.
  function automatic logic [5:0] wc_to_n(input logic [4:0] wc);
    return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
  endfunction

  function automatic logic [15:0] status_word(input logic [4:0] rt, input logic me);
    logic [15:0] s;
    s         = '0;
    s[15:11]  = rt;
    s[ME_BIT] = me;
    return s;
  endfunction

endpackage

// File: rtl/mkio_timer.sv
// Loadable down-counter shared by the response gap and the word timeout.
module mkio_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Flags the last counted cycle so the consumer transitions exactly load_val cycles after loading.
  assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/mkio_rt_sequencer.sv
// MKIO remote-terminal transaction sequencer: command lock-on, DEV2 receive, DEV4 transmit, status reply.
module mkio_rt_sequencer
  import mkio_pkg::*;
#(
  parameter logic [4:0]  RT_ADDR      = 5'd1,
  parameter logic [4:0]  RX_SUBADDR   = 5'd2,
  parameter logic [4:0]  TX_SUBADDR   = 5'd4,
  parameter int unsigned GAP_CYCLES   = 128,
  parameter int unsigned WORD_TIMEOUT = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxa_valid,
  input  logic        rxa_sync,
  input  logic [15:0] rxa_data,
  input  logic        rxa_err,
  input  logic        rxb_valid,
  input  logic        rxb_sync,
  input  logic [15:0] rxb_data,
  input  logic        rxb_err,
  output logic        tx_req,
  output logic        tx_sync,
  output logic [15:0] tx_data,
  output logic        tx_chan,
  input  logic        tx_ack,
  input  logic        tx_busy,
  output logic        tx_inhibit_a,
  output logic        tx_inhibit_b,
  output logic        m2_we,
  output logic [4:0]  m2_addr,
  output logic [15:0] m2_wdata,
  output logic [4:0]  m4_addr,
  input  logic [15:0] m4_rdata,
  output logic        busy_dev2,
  output logic        busy_dev4,
  output logic        msg_done,
  output logic        msg_err
);

  localparam int unsigned TMR_MAX = (GAP_CYCLES > WORD_TIMEOUT) ? GAP_CYCLES : WORD_TIMEOUT;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);

  seq_state_e state_q, state_d;
  logic       chan_q, me_q, rx_ok_q, tx_ok_q;
  logic [5:0] n_q, idx_q;

  cmd_word_t  cmd_a, cmd_b, cmd_new;
  logic       hit_a, hit_b, take_cmd, new_chan, cmd_rx_ok, cmd_tx_ok;
  logic       act_valid, act_sync, act_err;
  logic [15:0] act_data;
  logic       load_gap, load_to, do_wr, do_adv, do_abort, do_done, tmr_exp;
  logic [TW-1:0] tmr_val;

  assign cmd_a     = cmd_word_t'(rxa_data);
  assign cmd_b     = cmd_word_t'(rxb_data);
  assign hit_a     = rxa_valid & rxa_sync & ~rxa_err & (cmd_a.addr == RT_ADDR);
  assign hit_b     = rxb_valid & rxb_sync & ~rxb_err & (cmd_b.addr == RT_ADDR);
  assign take_cmd  = hit_a | hit_b;
  assign new_chan  = ~hit_a;
  assign cmd_new   = hit_a ? cmd_a : cmd_b;
  assign cmd_rx_ok = ~cmd_new.tr & (cmd_new.sa == RX_SUBADDR);
  assign cmd_tx_ok =  cmd_new.tr & (cmd_new.sa == TX_SUBADDR);

  assign act_valid = chan_q ? rxb_valid : rxa_valid;
  assign act_sync  = chan_q ? rxb_sync  : rxa_sync;
  assign act_err   = chan_q ? rxb_err   : rxa_err;
  assign act_data  = chan_q ? rxb_data  : rxa_data;

  assign tmr_val = load_gap ? TW'(GAP_CYCLES) : TW'(WORD_TIMEOUT);

  mkio_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_gap | load_to),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // A self-addressed command wins over everything else, in any state.
  always_comb begin
    state_d  = state_q;
    load_gap = 1'b0;
    load_to  = 1'b0;
    do_wr    = 1'b0;
    do_adv   = 1'b0;
    do_abort = 1'b0;
    do_done  = 1'b0;
    if (take_cmd) begin
      state_d  = cmd_new.tr ? GAP : RX_DATA;
      load_gap = cmd_new.tr;
      load_to  = ~cmd_new.tr;
    end else begin
      unique case (state_q)
        IDLE: ;
        RX_DATA: begin
          if (act_valid) begin
            if (act_err || act_sync) begin
              do_abort = 1'b1;
              state_d  = IDLE;
            end else begin
              do_wr = 1'b1;
              if (idx_q + 6'd1 == n_q) begin
                state_d  = GAP;
                load_gap = 1'b1;
              end else begin
                load_to = 1'b1;
              end
            end
          end else if (tmr_exp) begin
            do_abort = 1'b1;
            state_d  = IDLE;
          end
        end
        GAP:       if (tmr_exp) state_d = TX_STATUS;
        TX_STATUS: if (tx_ack) state_d = tx_ok_q ? TX_RD : DRAIN;
        TX_RD:     state_d = TX_DATA;
        TX_DATA: begin
          if (tx_ack) begin
            do_adv  = 1'b1;
            state_d = (idx_q + 6'd1 < n_q) ? TX_RD : DRAIN;
          end
        end
        DRAIN: begin
          if (!tx_busy) begin
            do_done = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chan_q   <= 1'b0;
      me_q     <= 1'b0;
      rx_ok_q  <= 1'b0;
      tx_ok_q  <= 1'b0;
      n_q      <= '0;
      idx_q    <= '0;
      m2_we    <= 1'b0;
      m2_addr  <= '0;
      m2_wdata <= '0;
      msg_done <= 1'b0;
      msg_err  <= 1'b0;
    end else begin
      m2_we    <= 1'b0;
      msg_done <= do_done;
      msg_err  <= do_abort | (take_cmd & (state_q != IDLE));
      if (take_cmd) begin
        chan_q  <= new_chan;
        n_q     <= wc_to_n(cmd_new.wc);
        idx_q   <= '0;
        rx_ok_q <= cmd_rx_ok;
        tx_ok_q <= cmd_tx_ok;
        me_q    <= ~(cmd_rx_ok | cmd_tx_ok);
      end else begin
        if (do_wr && rx_ok_q) begin
          m2_we    <= 1'b1;
          m2_addr  <= idx_q[4:0];
          m2_wdata <= act_data;
        end
        if (do_wr || do_adv) idx_q <= idx_q + 6'd1;
        if (state_d == IDLE) me_q <= 1'b0;
      end
    end
  end

  always_comb begin
    tx_req    = 1'b0;
    tx_sync   = 1'b0;
    tx_data   = '0;
    busy_dev2 = 1'b0;
    busy_dev4 = 1'b0;
    unique case (state_q)
      RX_DATA: busy_dev2 = rx_ok_q;
      GAP, TX_RD: busy_dev4 = tx_ok_q;
      TX_STATUS: begin
        tx_req    = 1'b1;
        tx_sync   = 1'b1;
        tx_data   = status_word(RT_ADDR, me_q);
        busy_dev4 = tx_ok_q;
      end
      TX_DATA: begin
        tx_req    = 1'b1;
        tx_data   = m4_rdata;
        busy_dev4 = tx_ok_q;
      end
      default: ;
    endcase
  end

  assign tx_chan      = chan_q;
  assign m4_addr      = idx_q[4:0];
  assign tx_inhibit_a = (state_q != IDLE) &  chan_q;
  assign tx_inhibit_b = (state_q != IDLE) & ~chan_q;

endmodule

// File: tb/tb_mkio_rt_sequencer.sv
// Scoreboard bench for mkio_rt_sequencer with DEV4 and encoder models.
module tb_mkio_rt_sequencer;

  localparam int GAP   = 128;
  localparam int TMO   = 768;
  localparam int BUSYC = 20;

  logic        clk, rst;
  logic        rxa_valid, rxa_sync, rxa_err, rxb_valid, rxb_sync, rxb_err;
  logic [15:0] rxa_data, rxb_data;
  logic        tx_req, tx_sync, tx_chan, tx_ack, tx_busy;
  logic [15:0] tx_data;
  logic        tx_inhibit_a, tx_inhibit_b, m2_we, busy_dev2, busy_dev4, msg_done, msg_err;
  logic [4:0]  m2_addr, m4_addr;
  logic [15:0] m2_wdata, m4_rdata;

  mkio_rt_sequencer #(
    .RT_ADDR(5'd1), .RX_SUBADDR(5'd2), .TX_SUBADDR(5'd4), .GAP_CYCLES(GAP), .WORD_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rxa_valid(rxa_valid), .rxa_sync(rxa_sync), .rxa_data(rxa_data), .rxa_err(rxa_err),
    .rxb_valid(rxb_valid), .rxb_sync(rxb_sync), .rxb_data(rxb_data), .rxb_err(rxb_err),
    .tx_req(tx_req), .tx_sync(tx_sync), .tx_data(tx_data), .tx_chan(tx_chan),
    .tx_ack(tx_ack), .tx_busy(tx_busy),
    .tx_inhibit_a(tx_inhibit_a), .tx_inhibit_b(tx_inhibit_b),
    .m2_we(m2_we), .m2_addr(m2_addr), .m2_wdata(m2_wdata),
    .m4_addr(m4_addr), .m4_rdata(m4_rdata),
    .busy_dev2(busy_dev2), .busy_dev4(busy_dev4),
    .msg_done(msg_done), .msg_err(msg_err)
  );

  int checks = 0, errors = 0;
  logic [20:0] exp_wr[$];
  logic [17:0] exp_tx[$];
  logic [20:0] mon_e;
  logic [17:0] enc_e;
  logic [15:0] dev4[32];
  logic [4:0]  rd_a;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0, req_rises = 0, ncyc = 0;
  int last_rx_cyc = 0, stat_rise_cyc = 0;
  logic req_prev = 1'b0, busy4_at_ack = 1'b0, busy4_after_ack = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DEV4: synchronous read, data one cycle after the address.
  initial begin
    m4_rdata = '0;
    forever begin
      @(negedge clk); rd_a = m4_addr;
      @(posedge clk); #1 m4_rdata = dev4[rd_a];
    end
  end

  // Encoder: acks a held request after a cycle, then stays busy while shifting.
  initial begin
    tx_ack = 1'b0; tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst && tx_req) begin
        @(posedge clk); #1;
        if (rst && tx_req) begin
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_word unexpected: got chan %0d sync %0d data %h, required none", tx_chan, tx_sync, tx_data);
          end else begin
            enc_e = exp_tx.pop_front();
            if ({tx_chan, tx_sync, tx_data} !== enc_e) begin
              errors++;
              $display("FAIL tx_word: got chan %0d sync %0d data %h, required chan %0d sync %0d data %h",
                       tx_chan, tx_sync, tx_data, enc_e[17], enc_e[16], enc_e[15:0]);
            end
          end
          busy4_at_ack = busy_dev4;
          tx_ack = 1'b1; tx_busy = 1'b1;
          @(posedge clk); #1;
          tx_ack = 1'b0;
          busy4_after_ack = busy_dev4;
          repeat (BUSYC) @(posedge clk);
          #1 tx_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: DEV2 writes against the scoreboard, plus event counters.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        if (rxa_valid || rxb_valid) last_rx_cyc = ncyc;
        if (tx_req && !req_prev) begin
          req_rises++;
          if (tx_sync) stat_rise_cyc = ncyc;
        end
        if (msg_done) done_cnt++;
        if (msg_err) err_cnt++;
        if (m2_we) begin
          wr_cnt++;
          checks++;
          if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL m2_write unexpected: got addr %0d data %h, required none", m2_addr, m2_wdata);
          end else begin
            mon_e = exp_wr.pop_front();
            if ({m2_addr, m2_wdata} !== mon_e) begin
              errors++;
              $display("FAIL m2_write: got addr %0d data %h, required addr %0d data %h",
                       m2_addr, m2_wdata, mon_e[20:16], mon_e[15:0]);
            end
          end
        end
      end
      req_prev = tx_req;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic ch, input logic sync, input logic [15:0] d, input logic err);
    @(posedge clk); #1;
    if (ch) begin rxb_valid = 1'b1; rxb_sync = sync; rxb_data = d; rxb_err = err; end
    else    begin rxa_valid = 1'b1; rxa_sync = sync; rxa_data = d; rxa_err = err; end
    @(posedge clk); #1;
    rxa_valid = 1'b0; rxb_valid = 1'b0; rxa_err = 1'b0; rxb_err = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin @(posedge clk); n++; end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rxa_valid = 0; rxa_sync = 0; rxa_data = '0; rxa_err = 0;
    rxb_valid = 0; rxb_sync = 0; rxb_data = '0; rxb_err = 0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({tx_req, tx_sync, tx_data, tx_chan, tx_inhibit_a, tx_inhibit_b, m2_we, m2_addr, m2_wdata,
         m4_addr, busy_dev2, busy_dev4, msg_done, msg_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req %b data %h inh %b%b we %b busy %b%b, required all 0",
               tx_req, tx_data, tx_inhibit_a, tx_inhibit_b, m2_we, busy_dev2, busy_dev4);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({tx_inhibit_a, tx_inhibit_b, tx_req} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got inh %b%b req %b, required 000", tx_inhibit_a, tx_inhibit_b, tx_req);
    end
  endtask

  task automatic test_rx_basic();
    int d0 = done_cnt;
    logic [15:0] d;
    send(1'b0, 1'b1, 16'h0847, 1'b0);
    checks++;
    if ({tx_inhibit_a, tx_inhibit_b, busy_dev2} !== 3'b011) begin
      errors++; $display("FAIL rx_inhibit: got inh_a %b inh_b %b busy2 %b, required 0 1 1", tx_inhibit_a, tx_inhibit_b, busy_dev2);
    end
    for (int i = 0; i < 7; i++) begin
      d = 16'($urandom);
      exp_wr.push_back({5'(i), d});
      send(1'b0, 1'b0, d, 1'b0);
      if (i == 0) begin
        checks++;
        if ({m2_we, m2_addr} !== 6'b1_00000) begin
          errors++; $display("FAIL rx_write_latency: got we %b addr %0d, required we 1 addr 0", m2_we, m2_addr);
        end
      end
    end
    exp_tx.push_back({1'b0, 1'b1, 16'h0800});
    wait_done(d0 + 1, 1000);
    checks++;
    if (done_cnt !== d0 + 1) begin errors++; $display("FAIL rx_done: got %0d, required %0d", done_cnt, d0 + 1); end
    checks++;
    if (stat_rise_cyc - last_rx_cyc !== GAP + 1) begin
      errors++; $display("FAIL rx_gap: got %0d cycles, required %0d", stat_rise_cyc - last_rx_cyc, GAP + 1);
    end
    checks++;
    if (exp_wr.size() != 0 || exp_tx.size() != 0 || {tx_inhibit_a, tx_inhibit_b} !== 2'b00) begin
      errors++; $display("FAIL rx_end: got pending wr %0d tx %0d inh %b%b, required 0 0 00",
                         exp_wr.size(), exp_tx.size(), tx_inhibit_a, tx_inhibit_b);
    end
  endtask

  task automatic test_tx();
    int d0 = done_cnt;
    for (int i = 0; i < 5; i++) dev4[i] = 16'($urandom);
    exp_tx.push_back({1'b1, 1'b1, 16'h0800});
    for (int i = 0; i < 5; i++) exp_tx.push_back({1'b1, 1'b0, dev4[i]});
    send(1'b1, 1'b1, 16'h0C85, 1'b0);
    checks++;
    if ({tx_inhibit_a, tx_inhibit_b, busy_dev4} !== 3'b101) begin
      errors++; $display("FAIL tx_inhibit: got inh_a %b inh_b %b busy4 %b, required 1 0 1", tx_inhibit_a, tx_inhibit_b, busy_dev4);
    end
    wait_done(d0 + 1, 1500);
    checks++;
    if (done_cnt !== d0 + 1 || exp_tx.size() != 0) begin
      errors++; $display("FAIL tx_done: got done %0d pending %0d, required %0d 0", done_cnt, exp_tx.size(), d0 + 1);
    end
    checks++;
    if ({busy4_at_ack, busy4_after_ack} !== 2'b10) begin
      errors++; $display("FAIL tx_busy4: got at_ack %b after_ack %b, required 1 0", busy4_at_ack, busy4_after_ack);
    end
    checks++;
    if (stat_rise_cyc - last_rx_cyc !== GAP + 1) begin
      errors++; $display("FAIL tx_gap: got %0d cycles, required %0d", stat_rise_cyc - last_rx_cyc, GAP + 1);
    end
  endtask

  task automatic test_rx_n0();
    int d0 = done_cnt, w0 = wr_cnt;
    logic [15:0] d;
    send(1'b0, 1'b1, 16'h0840, 1'b0);
    for (int i = 0; i < 32; i++) begin
      d = 16'($urandom);
      exp_wr.push_back({5'(i), d});
      send(1'b0, 1'b0, d, 1'b0);
    end
    exp_tx.push_back({1'b0, 1'b1, 16'h0800});
    wait_done(d0 + 1, 1000);
    checks++;
    if (wr_cnt - w0 !== 32 || done_cnt !== d0 + 1 || exp_tx.size() != 0) begin
      errors++; $display("FAIL n0_writes: got writes %0d done %0d, required 32 %0d", wr_cnt - w0, done_cnt, d0 + 1);
    end
  endtask

  task automatic test_parity();
    int e0 = err_cnt, w0 = wr_cnt, r0 = req_rises;
    logic [15:0] d;
    send(1'b0, 1'b1, 16'h0845, 1'b0);
    for (int i = 0; i < 2; i++) begin
      d = 16'($urandom);
      exp_wr.push_back({5'(i), d});
      send(1'b0, 1'b0, d, 1'b0);
    end
    send(1'b0, 1'b0, 16'hDEAD, 1'b1);
    repeat (GAP + 30) @(posedge clk); #1;
    checks++;
    if (wr_cnt - w0 !== 2 || err_cnt !== e0 + 1) begin
      errors++; $display("FAIL parity_abort: got writes %0d err %0d, required 2 %0d", wr_cnt - w0, err_cnt, e0 + 1);
    end
    checks++;
    if (req_rises !== r0 || {tx_inhibit_a, tx_inhibit_b} !== 2'b00) begin
      errors++; $display("FAIL parity_no_status: got req_rises %0d inh %b%b, required %0d 00", req_rises, tx_inhibit_a, tx_inhibit_b, r0);
    end
  endtask

  task automatic test_supersede();
    int d0 = done_cnt, e0 = err_cnt;
    logic [15:0] d;
    send(1'b0, 1'b1, 16'h0847, 1'b0);
    for (int i = 0; i < 2; i++) begin
      d = 16'($urandom);
      exp_wr.push_back({5'(i), d});
      send(1'b0, 1'b0, d, 1'b0);
    end
    for (int i = 0; i < 2; i++) dev4[i] = 16'($urandom);
    exp_tx.push_back({1'b1, 1'b1, 16'h0800});
    for (int i = 0; i < 2; i++) exp_tx.push_back({1'b1, 1'b0, dev4[i]});
    send(1'b1, 1'b1, 16'h0C82, 1'b0);
    checks++;
    if ({tx_inhibit_a, tx_inhibit_b, busy_dev2, busy_dev4} !== 4'b1001) begin
      errors++; $display("FAIL sup_switch: got inh %b%b busy %b%b, required 10 01", tx_inhibit_a, tx_inhibit_b, busy_dev2, busy_dev4);
    end
    wait_done(d0 + 1, 1500);
    checks++;
    if (err_cnt !== e0 + 1 || done_cnt !== d0 + 1 || exp_tx.size() != 0 || exp_wr.size() != 0) begin
      errors++; $display("FAIL sup_result: got err %0d done %0d pending tx %0d, required %0d %0d 0",
                         err_cnt, done_cnt, exp_tx.size(), e0 + 1, d0 + 1);
    end
  endtask

  task automatic test_ignore_illegal();
    int d0 = done_cnt, w0 = wr_cnt, r0 = req_rises;
    send(1'b0, 1'b1, 16'h1847, 1'b0);
    checks++;
    if ({tx_inhibit_a, tx_inhibit_b, busy_dev2} !== 3'b000) begin
      errors++; $display("FAIL other_addr: got inh %b%b busy2 %b, required 000", tx_inhibit_a, tx_inhibit_b, busy_dev2);
    end
    send(1'b0, 1'b0, 16'h1111, 1'b0);
    send(1'b1, 1'b1, 16'hF847, 1'b0);
    checks++;
    if ({tx_inhibit_a, tx_inhibit_b} !== 2'b00 || wr_cnt !== w0 || req_rises !== r0) begin
      errors++; $display("FAIL bcast_addr: got inh %b%b writes %0d, required 00 %0d", tx_inhibit_a, tx_inhibit_b, wr_cnt, w0);
    end
    send(1'b0, 1'b1, 16'h08A2, 1'b0);
    checks++;
    if ({tx_inhibit_b, busy_dev2} !== 2'b10) begin
      errors++; $display("FAIL illegal_rx: got inh_b %b busy2 %b, required 1 0", tx_inhibit_b, busy_dev2);
    end
    send(1'b0, 1'b0, 16'h2222, 1'b0);
    send(1'b0, 1'b0, 16'h3333, 1'b0);
    exp_tx.push_back({1'b0, 1'b1, 16'h0C00});
    wait_done(d0 + 1, 1000);
    checks++;
    if (wr_cnt !== w0 || done_cnt !== d0 + 1 || exp_tx.size() != 0) begin
      errors++; $display("FAIL illegal_status: got writes %0d done %0d pending %0d, required %0d %0d 0",
                         wr_cnt, done_cnt, exp_tx.size(), w0, d0 + 1);
    end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt, r0 = req_rises;
    logic [15:0] d = 16'($urandom);
    send(1'b0, 1'b1, 16'h0843, 1'b0);
    exp_wr.push_back({5'd0, d});
    send(1'b0, 1'b0, d, 1'b0);
    repeat (TMO - 20) @(posedge clk); #1;
    checks++;
    if (tx_inhibit_b !== 1'b1 || err_cnt !== e0) begin
      errors++; $display("FAIL timeout_early: got inh_b %b err %0d, required 1 %0d", tx_inhibit_b, err_cnt, e0);
    end
    repeat (60) @(posedge clk); #1;
    checks++;
    if (err_cnt !== e0 + 1 || tx_inhibit_b !== 1'b0 || req_rises !== r0 || exp_wr.size() != 0) begin
      errors++; $display("FAIL timeout_abort: got err %0d inh_b %b, required %0d 0", err_cnt, tx_inhibit_b, e0 + 1);
    end
  endtask

  task automatic test_ab_tie();
    int d0 = done_cnt;
    dev4[0] = 16'($urandom);
    exp_tx.push_back({1'b0, 1'b1, 16'h0800});
    exp_tx.push_back({1'b0, 1'b0, dev4[0]});
    @(posedge clk); #1;
    rxa_valid = 1; rxa_sync = 1; rxa_data = 16'h0C81; rxa_err = 0;
    rxb_valid = 1; rxb_sync = 1; rxb_data = 16'h0C82; rxb_err = 0;
    @(posedge clk); #1;
    rxa_valid = 0; rxb_valid = 0;
    checks++;
    if ({tx_inhibit_a, tx_inhibit_b} !== 2'b01) begin
      errors++; $display("FAIL tie_chan: got inh %b%b, required 01", tx_inhibit_a, tx_inhibit_b);
    end
    wait_done(d0 + 1, 1000);
    checks++;
    if (done_cnt !== d0 + 1 || exp_tx.size() != 0) begin
      errors++; $display("FAIL tie_done: got done %0d pending %0d, required %0d 0", done_cnt, exp_tx.size(), d0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send(1'b0, 1'b1, 16'h0C81, 1'b0);
    while (tx_req !== 1'b1 && n < GAP + 40) begin @(negedge clk); n++; end
    checks++;
    if (tx_req !== 1'b1) begin errors++; $display("FAIL mid_req: got tx_req %b, required 1", tx_req); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({tx_req, tx_sync, tx_data, tx_inhibit_a, tx_inhibit_b, busy_dev4, m4_addr} !== '0) begin
      errors++; $display("FAIL mid_reset: got req %b data %h inh %b%b busy4 %b, required all 0",
                         tx_req, tx_data, tx_inhibit_a, tx_inhibit_b, busy_dev4);
    end
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    repeat (40) @(posedge clk); #1;
    checks++;
    if ({tx_req, tx_inhibit_a, tx_inhibit_b} !== 3'b000) begin
      errors++; $display("FAIL post_reset_idle: got req %b inh %b%b, required 000", tx_req, tx_inhibit_a, tx_inhibit_b);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) dev4[i] = 16'($urandom);
    test_reset();
    test_rx_basic();
    test_tx();
    test_rx_n0();
    test_parity();
    test_supersede();
    test_ignore_illegal();
    test_timeout();
    test_ab_tie();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mkio_rt_sequencer.md
# mkio_rt_sequencer

Transaction sequencer for the MKIO remote terminal, sitting between the two channel word decoders/encoders (A, B) and the device memories DEV2 (receive buffer, subaddress 2) and DEV4 (transmit buffer, subaddress 4). It locks onto the channel that carried a valid command, moves data words into DEV2 or out of DEV4, and issues the status word after the response gap. It also drives the per-channel transmit inhibits, handles superseding commands, and reports message errors.

## Interface
Parameters:
- RT_ADDR, 5'd1, terminal address.
- RX_SUBADDR, 5'd2, subaddress for receive commands (T/R=0) into DEV2.
- TX_SUBADDR, 5'd4, subaddress for transmit commands (T/R=1) from DEV4.
- GAP_CYCLES, 128, response gap in clk cycles (4 µs at 32 MHz).
- WORD_TIMEOUT, 768, maximum gap between consecutive receive data words (24 µs).

Ports:
- clk  in  1  32 MHz system clock.
- rst  in  1  reset. Asynchronous and active-low.
- rxa_valid, rxb_valid  in  1  one-cycle pulse: word decoded on channel A / B.
- rxa_sync, rxb_sync  in  1  1 = command/status sync, 0 = data sync.
- rxa_data, rxb_data  in  16  decoded word.
- rxa_err, rxb_err  in  1  Manchester or parity error on the word (valid with rx*_valid).
- tx_req  out  1  word request to the encoder. Held until tx_ack.
- tx_sync  out  1  sync type for the requested word.
- tx_data  out  16  word to send.
- tx_chan  out  1  0 = A, 1 = B.
- tx_ack  in  1  one-cycle pulse: encoder has loaded the word.
- tx_busy  in  1  encoder is still shifting.
- tx_inhibit_a, tx_inhibit_b  out  1  inhibit for the inactive channel.
- m2_we  out  1  DEV2 write strobe.
- m2_addr  out  5  DEV2 write address.
- m2_wdata  out  16  DEV2 write data.
- m4_addr  out  5  DEV4 read address. Read data is valid 1 cycle later.
- m4_rdata  in  16  DEV4 read data.
- busy_dev2, busy_dev4  out  1  memory owned by the sequencer.
- msg_done, msg_err  out  1  one-cycle completion / error pulses.

## Operation
- Command word fields: [15:11] address, [10] T/R, [9:5] subaddress, [4:0] word count N. N=0 means 32.
- Status word: {RT_ADDR, ME, 10'b0}. ME is bit 10.
- States: IDLE, RX_DATA, GAP, TX_STATUS, TX_RD, TX_DATA, DRAIN.
- IDLE: a word with valid=1, sync=1, err=0 and address RT_ADDR is accepted as a command. That channel becomes the active channel. Other addresses, including 31, are ignored. If A and B both present a command in the same cycle, A wins.
- Legal receive command (T/R=0, SA=RX_SUBADDR) -> RX_DATA with busy_dev2=1.
- Legal transmit command (T/R=1, SA=TX_SUBADDR) -> GAP with busy_dev4=1.
- Illegal receive command -> RX_DATA with writes suppressed and ME=1.
- Illegal transmit command -> GAP with ME=1 and no data words.
- RX_DATA: each clean data word (sync=0) on the active channel produces one write: m2_we=1 for one cycle, m2_addr = word index 0..N-1. After the N-th word -> GAP and busy_dev2=0.
- RX_DATA abort: an error word, a non-self-addressed sync word, or WORD_TIMEOUT on the active channel -> msg_err pulse, IDLE, no status. Writes already made are kept.
- GAP: count GAP_CYCLES, then TX_STATUS.
- TX_STATUS: tx_req=1, tx_sync=1, tx_data = status word.
- After the status is acknowledged: receive (or illegal) -> DRAIN; legal transmit -> TX_RD.
- TX_RD: drive m4_addr = i, then go to TX_DATA.
- TX_DATA: tx_req with tx_sync=0 and tx_data = m4_rdata. On tx_ack: i++. If i<N -> TX_RD, else busy_dev4=0 and DRAIN.
- DRAIN: wait for tx_busy=0, then msg_done pulse and IDLE. ME clears on return to IDLE.
- Supersede: in any non-IDLE state, a valid self-addressed command on either channel aborts the current message. This raises msg_err and drops tx_req, then the new command is processed on its own channel as in IDLE. It takes precedence over any simultaneous active-channel word.
- Data words on the inactive channel are ignored.
- tx_inhibit of the non-active channel is 1 in every non-IDLE state. Both inhibits are 0 in IDLE.

## Timing
- Reset (rst=0) asynchronously forces IDLE, all outputs 0, and counters/ME cleared. This also applies mid-message; the encoder request disappears immediately.
- Command accepted at cycle c: tx_inhibit asserts at c+1.
- m2 write occurs in the cycle after the matching rx*_valid.
- GAP counter starts the cycle after the last receive word, or after the command for transmit. tx_req rises exactly GAP_CYCLES cycles later.
- TX_RD costs one cycle per word, so tx_req is low for at least 1 cycle between data words.
- The timeout counter reloads on every accepted word on the active channel.

## Structure
- Shared package mkio_pkg: state enum; command-word field slices and a packed struct; status bit positions (ME=10); N=0 -> 32 conversion.
- One sub-module, mkio_timer: a loadable down-counter with an expire flag, used for both GAP and WORD_TIMEOUT.

## Test plan
- Receive command 0x0847 (addr 1, R, SA2, N=7) on A + 7 data words -> DEV2 writes at addresses 0..6 with matching data; tx_inhibit_b=1; status 0x0800 on A 128 cycles after the last word; msg_done.
- Preload DEV4[0..4], then transmit command 0x0C85 on B -> status 0x0800 then DEV4[0..4] in order on B (tx_chan=1); busy_dev4 drops after the 5th ack.
- Receive command with N=0 -> 32 writes at addresses 0..31, then status.
- Parity error on the 3rd data word -> exactly 2 writes, msg_err, no tx_req.
- Receive command on A; after 2 data words, transmit command 0x0C82 on B -> msg_err, status 0x0800 plus 2 words on B; tx_inhibit_a=1.
- Command to addr 3 -> no outputs change. Receive command to SA5 with N=2 + 2 data words -> no writes; status 0x0C00.
